// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one operand bit pair per clock, LSB first,
// through a full adder built from two half adders, with registered result flags.

module half_adder_core (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic hs, hc0, hc1, fs, fc;

    half_adder_core u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(hs), .c(hc0));
    half_adder_core u_ha1 (.a(hs),      .b(carry),   .s(fs), .c(hc1));
    assign fc = hc0 | hc1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B here, seed the carry with sub
                        a_sr  <= op_a;
                        b_sr  <= op_b ^ {WIDTH{sub}};
                        carry <= sub;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= {fs, acc[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fc;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this edge
                        sum      <= {fs, acc[WIDTH-1:1]};
                        c_out    <= fc;
                        overflow <= carry ^ fc;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
